run_length_monitor: RTL and testbench
=====================================

RUN_LENGTH_MONITOR -- requirements
Module: run_length_monitor

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, as the bit width of the sampled value.
REQ-002 The block SHALL take parameter CNT_W, default 32, as the width of the run counters.
REQ-003 The block SHALL take parameter THRESH, default 4, as the repeat count that fires hit; legal range 1..2^CNT_W-1.
REQ-004 The block SHALL have clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-005 The block SHALL have rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have in_valid, input, 1 bit: val is a sample this cycle.
REQ-007 The block SHALL have val, input, WIDTH bits: sampled value.
REQ-008 The block SHALL have clear, input, 1 bit: synchronous clear of all tracking state.
REQ-009 The block SHALL have run_val, output, WIDTH bits: value of the current run.
REQ-010 The block SHALL have run_cnt, output, CNT_W bits: consecutive repeats of run_val (0 on the first sample of a run).
REQ-011 The block SHALL have max_run, output, CNT_W bits: largest run_cnt reached since reset/clear.
REQ-012 The block SHALL have primed, output, 1 bit: high when the block is in state TRACK.
REQ-013 The block SHALL have hit, output, 1 bit: one-cycle pulse when run_cnt reaches THRESH.
REQ-014 The block SHALL have sat, output, 1 bit: high while run_cnt is all ones.

Function
REQ-015 The block SHALL implement two states: EMPTY (no reference sample held) and TRACK.
REQ-016 In EMPTY, in_valid=1 SHALL load run_val<=val and run_cnt<=0, then move to TRACK; no comparison is made.
REQ-017 In TRACK, in_valid=1 with val==run_val SHALL increment run_cnt by 1.
REQ-018 In TRACK, in_valid=1 with val!=run_val SHALL load run_val<=val and run_cnt<=0; state stays TRACK.
REQ-019 When in_valid=0, all registers SHALL hold and hit SHALL be 0.
REQ-020 run_cnt SHALL saturate: an increment at all ones holds the value; sat is derived combinationally from run_cnt.
REQ-021 max_run SHALL update on the same edge as run_cnt, to max(max_run, next run_cnt); it never decreases except on clear/reset.
REQ-022 hit SHALL be registered: it is 1 for exactly the cycle after the edge where run_cnt increments to THRESH, and 0 otherwise.
REQ-023 Once saturated, hit SHALL NOT refire; a run reaching THRESH fires hit once.
REQ-024 Latency SHALL be 1 clock: a sample applied before edge N is reflected on all outputs after edge N.
REQ-025 clear=1 SHALL take priority over in_valid: at the edge, state<=EMPTY and run_val, run_cnt, max_run and hit <=0. The sample presented that cycle is discarded.
REQ-026 Equality SHALL compare all WIDTH bits; there is no masking.

Reset
REQ-027 On asserted rst, the block SHALL immediately (asynchronously) set state=EMPTY, run_val=0, run_cnt=0, max_run=0 and hit=0; hence primed=0 and sat=0.
REQ-028 rst SHALL override clear and in_valid; rst asserted mid-run SHALL lose the run, and the first valid sample after release SHALL only prime the block.
REQ-029 After reset, an initial val=0 SHALL NOT count as a repeat of the reset run_val, because EMPTY suppresses the compare.

Verification
REQ-030 The bench SHALL cover priming: after reset, send valid samples 0x00, 0x00, 0x00 -> run_cnt 0,1,2; primed=1 after the first sample; max_run=2.
REQ-031 The bench SHALL cover the threshold: with THRESH=4, send 0x5A six times -> run_cnt 0..5; hit high only in the cycle where run_cnt=4.
REQ-032 The bench SHALL cover a value change and gaps: send 0x11 x3, 0x22, then in_valid=0 for 3 cycles, then 0x22 -> run_cnt 0,1,2,0, hold 0, 1; max_run=2.
REQ-033 The bench SHALL cover saturation: with CNT_W=3 and THRESH=7, send 0xAA ten times -> run_cnt sticks at 7, sat=1, hit pulses once, max_run=7.
REQ-034 The bench SHALL cover clear priority: assert clear together with a valid repeating sample mid-run (run_cnt=3) -> next cycle primed=0 and run_cnt=max_run=0; the next sample only primes the block.
REQ-035 The bench SHALL cover asynchronous reset: assert rst between clock edges mid-run -> outputs go to 0 before the next posedge.

Source files
------------

// File: rtl/run_length_monitor.sv
// Tracks the run length of consecutive identical valid samples. It also reports the
// longest run seen and pulses hit once when a run reaches THRESH repeats.
module run_length_monitor #(
    parameter int unsigned       WIDTH  = 8,
    parameter int unsigned       CNT_W  = 32,
    parameter logic [CNT_W-1:0]  THRESH = CNT_W'(4)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] val,
    input  logic             clear,
    output logic [WIDTH-1:0] run_val,
    output logic [CNT_W-1:0] run_cnt,
    output logic [CNT_W-1:0] max_run,
    output logic             primed,
    output logic             hit,
    output logic             sat
);

    typedef enum logic {
        EMPTY = 1'b0,
        TRACK = 1'b1
    } state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  run_val_q;
    logic [CNT_W-1:0]  run_cnt_q;
    logic [CNT_W-1:0]  max_run_q;
    logic              hit_q;

    logic              repeat_c;
    logic              at_max_c;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic [CNT_W-1:0]  run_cnt_d;

    // EMPTY holds no reference, so the first sample never counts as a repeat.
    always_comb begin
        repeat_c  = (state_q == TRACK) && (val == run_val_q);
        at_max_c  = &run_cnt_q;
        cnt_inc_c = at_max_c ? run_cnt_q : run_cnt_q + CNT_W'(1);
        run_cnt_d = repeat_c ? cnt_inc_c : '0;
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            run_val_q <= '0;
            run_cnt_q <= '0;
            max_run_q <= '0;
            hit_q     <= 1'b0;
        end else if (clear) begin
            state_q   <= EMPTY;
            run_val_q <= '0;
            run_cnt_q <= '0;
            max_run_q <= '0;
            hit_q     <= 1'b0;
        end else begin
            hit_q <= 1'b0;
            if (in_valid) begin
                state_q   <= TRACK;
                run_val_q <= val;
                run_cnt_q <= run_cnt_d;
                if (run_cnt_d > max_run_q) begin
                    max_run_q <= run_cnt_d;
                end
                // A saturated counter is not incrementing, so hit cannot refire.
                hit_q <= repeat_c && !at_max_c && (cnt_inc_c == THRESH);
            end
        end
    end

    assign run_val = run_val_q;
    assign run_cnt = run_cnt_q;
    assign max_run = max_run_q;
    assign primed  = (state_q == TRACK);
    assign hit     = hit_q;
    assign sat     = &run_cnt_q;

endmodule

// File: tb/tb_run_length_monitor.sv
// Directed scoreboard bench for run_length_monitor: instance A uses the defaults and
// instance B is a narrow counter (CNT_W=3, THRESH=7) that exercises saturation.
module tb_run_length_monitor;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] val;
    logic       clear;

    logic [7:0]  run_val_a, run_val_b;
    logic [31:0] run_cnt_a, max_run_a;
    logic [2:0]  run_cnt_b, max_run_b;
    logic        primed_a, hit_a, sat_a;
    logic        primed_b, hit_b, sat_b;

    run_length_monitor #(.WIDTH(8), .CNT_W(32), .THRESH(32'd4)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .val      (val),
        .clear    (clear),
        .run_val  (run_val_a),
        .run_cnt  (run_cnt_a),
        .max_run  (max_run_a),
        .primed   (primed_a),
        .hit      (hit_a),
        .sat      (sat_a)
    );

    run_length_monitor #(.WIDTH(8), .CNT_W(3), .THRESH(3'd7)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .val      (val),
        .clear    (clear),
        .run_val  (run_val_b),
        .run_cnt  (run_cnt_b),
        .max_run  (max_run_b),
        .primed   (primed_b),
        .hit      (hit_b),
        .sat      (sat_b)
    );

    typedef struct {
        bit          sel;
        logic        primed;
        logic [7:0]  rv;
        logic [31:0] cnt;
        logic [31:0] mx;
        logic        hit;
        logic        sat;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [74:0] pack(input logic p, input logic [7:0] rv,
                                         input logic [31:0] c, input logic [31:0] m,
                                         input logic h, input logic s);
        return {p, rv, c, m, h, s};
    endfunction

    function automatic logic [74:0] observe(input bit sel);
        if (sel)
            return pack(primed_b, run_val_b, {29'd0, run_cnt_b}, {29'd0, max_run_b}, hit_b, sat_b);
        return pack(primed_a, run_val_a, run_cnt_a, max_run_a, hit_a, sat_a);
    endfunction

    task automatic check(input string name, input logic [74:0] got, input logic [74:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got {primed,run_val,run_cnt,max_run,hit,sat}=%h, expected %h",
                     name, got, want);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after its edge.
    task automatic step(input bit sel, input bit v, input logic [7:0] d, input bit clr,
                        input bit ep, input logic [7:0] ev, input int unsigned ec,
                        input int unsigned em, input bit eh, input string nm);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        val      = d;
        clear    = clr;
        e.sel    = sel;
        e.primed = ep;
        e.rv     = ev;
        e.cnt    = ec;
        e.mx     = em;
        e.hit    = eh;
        e.sat    = sel && (ec == 7);
        e.name   = nm;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: outputs settle one edge after each queued stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, observe(e.sel), pack(e.primed, e.rv, e.cnt, e.mx, e.hit, e.sat));
            end
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        val      = 8'h00;
        clear    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_a", observe(1'b0), '0);
        check("reset_b", observe(1'b1), '0);
        @(negedge clk);
        rst = 1'b0;

        // Priming: a zero sample after reset is not a repeat of the reset value.
        step(0, 1, 8'h00, 0, 1, 8'h00, 0, 0, 0, "prime_0");
        step(0, 1, 8'h00, 0, 1, 8'h00, 1, 1, 0, "prime_1");
        step(0, 1, 8'h00, 0, 1, 8'h00, 2, 2, 0, "prime_2");

        // Threshold: hit only on the cycle run_cnt becomes 4.
        step(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, "clear_thr");
        for (int i = 0; i < 6; i++)
            step(0, 1, 8'h5A, 0, 1, 8'h5A, i, i, (i == 4), $sformatf("thresh_%0d", i));

        // Value change and gaps.
        step(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, "clear_gap");
        step(0, 1, 8'h11, 0, 1, 8'h11, 0, 0, 0, "gap_11_0");
        step(0, 1, 8'h11, 0, 1, 8'h11, 1, 1, 0, "gap_11_1");
        step(0, 1, 8'h11, 0, 1, 8'h11, 2, 2, 0, "gap_11_2");
        step(0, 1, 8'h22, 0, 1, 8'h22, 0, 2, 0, "gap_22_new");
        for (int i = 0; i < 3; i++)
            step(0, 0, 8'h22, 0, 1, 8'h22, 0, 2, 0, $sformatf("gap_idle_%0d", i));
        step(0, 1, 8'h22, 0, 1, 8'h22, 1, 2, 0, "gap_22_rep");

        // Clear priority over a valid repeating sample.
        step(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, "clear_pri");
        for (int i = 0; i < 4; i++)
            step(0, 1, 8'h33, 0, 1, 8'h33, i, i, 0, $sformatf("pri_run_%0d", i));
        step(0, 1, 8'h33, 1, 0, 8'h00, 0, 0, 0, "pri_clear");
        step(0, 1, 8'h33, 0, 1, 8'h33, 0, 0, 0, "pri_reprime");

        // Saturation on the narrow instance.
        step(1, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, "clear_sat");
        for (int i = 0; i < 10; i++)
            step(1, 1, 8'hAA, 0, 1, 8'hAA, (i < 7) ? i : 7, (i < 7) ? i : 7, (i == 7),
                 $sformatf("sat_%0d", i));

        // Asynchronous reset between edges in the middle of a run.
        step(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, "clear_rst");
        step(0, 1, 8'h44, 0, 1, 8'h44, 0, 0, 0, "rst_run_0");
        step(0, 1, 8'h44, 0, 1, 8'h44, 1, 1, 0, "rst_run_1");
        step(0, 1, 8'h44, 0, 1, 8'h44, 2, 2, 0, "rst_run_2");
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_a", observe(1'b0), '0);
        check("async_rst_b", observe(1'b1), '0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(0, 1, 8'h00, 0, 1, 8'h00, 0, 0, 0, "post_rst_prime");
        step(0, 1, 8'h00, 0, 1, 8'h00, 1, 1, 0, "post_rst_rep");

        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
